// File: rtl/joybus_poll_ctrl.sv
// JoyBus poll sequencer for one controller port: schedules poll commands, hands the
// line from transmitter to receiver, watchdogs both phases and latches the response.
module joybus_poll_ctrl #(
   parameter int unsigned POLL_PERIOD = 416667,
   parameter int unsigned TIMEOUT     = 2500,
   parameter logic [7:0]  CMD_POLL    = 8'h01,
   parameter int unsigned MAX_MISS    = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        poll_now,
   output logic        tx_start,
   output logic [7:0]  tx_cmd,
   input  logic        tx_done,
   output logic        rx_start,
   input  logic        rx_done,
   input  logic [7:0]  jb_cntlr_status,
   input  logic [15:0] jb_cntlr_data,
   output logic [7:0]  btn_status,
   output logic [15:0] btn_data,
   output logic        upd,
   output logic        valid,
   output logic        ctrl_present,
   output logic [7:0]  err_cnt,
   output logic [1:0]  state_dbg
);

   localparam int PW = $clog2(POLL_PERIOD);
   localparam int WW = $clog2(TIMEOUT);
   localparam logic [PW-1:0] PER_LAST = PW'(POLL_PERIOD - 1);
   localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
   localparam logic [7:0]    MISS_LIM = 8'(MAX_MISS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_TX   = 2'd1,
      S_RX   = 2'd2
   } state_t;

   state_t        state, state_d;
   logic          pending, pend_d;
   logic [PW-1:0] per_cnt, per_d;
   logic [WW-1:0] wd_cnt, wd_d;
   logic [7:0]    miss_cnt, miss_d, miss_inc;
   logic [7:0]    err_d;
   logic          tx_start_d, rx_start_d, upd_d, valid_d, present_d;
   logic [7:0]    status_d;
   logic [15:0]   data_d;
   logic          per_wrap, wd_expire, take_miss;

   // Handshake: tx_start/rx_start are one-cycle requests to the PHY; tx_done/rx_done are
   // one-cycle completions, honoured only in the matching phase and ignored elsewhere.
   assign tx_cmd    = CMD_POLL;
   assign state_dbg = state;
   assign per_wrap  = en && (per_cnt == PER_LAST);
   assign wd_expire = (wd_cnt == WD_LAST);

   always_comb begin
      state_d    = state;
      pend_d     = en && (pending || per_wrap);
      per_d      = (!en || per_wrap) ? '0 : per_cnt + 1'b1;
      wd_d       = (state == S_IDLE) ? '0 : wd_cnt + 1'b1;
      miss_d     = miss_cnt;
      miss_inc   = (miss_cnt == MISS_LIM) ? miss_cnt : miss_cnt + 8'd1;
      err_d      = err_cnt;
      tx_start_d = 1'b0;
      rx_start_d = 1'b0;
      upd_d      = 1'b0;
      valid_d    = valid;
      present_d  = ctrl_present;
      status_d   = btn_status;
      data_d     = btn_data;
      take_miss  = 1'b0;

      if (en && poll_now && (state != S_IDLE)) begin
         pend_d = 1'b1;
      end

      case (state)
         S_IDLE: begin
            if (en && (pending || poll_now)) begin
               state_d    = S_TX;
               tx_start_d = 1'b1;
               wd_d       = '0;
               pend_d     = 1'b0;
            end
         end
         S_TX: begin
            if (tx_done) begin
               state_d    = S_RX;
               rx_start_d = 1'b1;
               wd_d       = '0;
            end else if (wd_expire) begin
               take_miss = 1'b1;
            end
         end
         S_RX: begin
            // A response arriving on the expiry edge still counts as a success.
            if (rx_done) begin
               state_d   = S_IDLE;
               status_d  = jb_cntlr_status;
               data_d    = jb_cntlr_data;
               upd_d     = 1'b1;
               valid_d   = 1'b1;
               present_d = 1'b1;
               miss_d    = 8'd0;
            end else if (wd_expire) begin
               take_miss = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (take_miss) begin
         state_d = S_IDLE;
         valid_d = 1'b0;
         err_d   = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
         miss_d  = miss_inc;
         if (miss_inc == MISS_LIM) begin
            present_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         pending      <= 1'b0;
         per_cnt      <= '0;
         wd_cnt       <= '0;
         miss_cnt     <= 8'd0;
         err_cnt      <= 8'd0;
         tx_start     <= 1'b0;
         rx_start     <= 1'b0;
         upd          <= 1'b0;
         valid        <= 1'b0;
         ctrl_present <= 1'b0;
         btn_status   <= 8'd0;
         btn_data     <= 16'd0;
      end else begin
         state        <= state_d;
         pending      <= pend_d;
         per_cnt      <= per_d;
         wd_cnt       <= wd_d;
         miss_cnt     <= miss_d;
         err_cnt      <= err_d;
         tx_start     <= tx_start_d;
         rx_start     <= rx_start_d;
         upd          <= upd_d;
         valid        <= valid_d;
         ctrl_present <= present_d;
         btn_status   <= status_d;
         btn_data     <= data_d;
      end
   end

endmodule

// File: tb/tb_joybus_poll_ctrl.sv
// Directed bench for joybus_poll_ctrl with a behavioural JoyBus TX/RX responder;
// expected values are hand-derived from the poll/watchdog timing.
module tb_joybus_poll_ctrl;

   localparam int P      = 200;
   localparam int TO     = 50;
   localparam int MM     = 2;
   localparam int TX_DLY = 20;

   logic        clk = 1'b0;
   logic        rst_n, en, poll_now, tx_done, rx_done;
   logic [7:0]  jb_cntlr_status;
   logic [15:0] jb_cntlr_data;
   logic        tx_start, rx_start, upd, valid, ctrl_present;
   logic [7:0]  tx_cmd, btn_status, err_cnt;
   logic [15:0] btn_data;
   logic [1:0]  state_dbg;

   // responder configuration, written by the main sequence
   logic        resp_tx, resp_rx;
   int          rx_dly;
   logic [7:0]  rsp_status;
   logic [15:0] rsp_data;

   // monitor bookkeeping
   int cyc = 0;
   int n_tx = 0, n_rx = 0, n_upd = 0;
   int last_tx_cyc = 0, last_txdone_cyc = 0, last_rxstart_cyc = 0, last_upd_cyc = 0, last_err_cyc = 0;
   logic [7:0] prev_err = 8'd0;
   int tx_cycs[$];
   int win[$];

   int n_checks = 0, n_fail = 0;
   int c0, t0, s, u, n0;

   joybus_poll_ctrl #(
      .POLL_PERIOD(P),
      .TIMEOUT    (TO),
      .CMD_POLL   (8'h01),
      .MAX_MISS   (MM)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .en             (en),
      .poll_now       (poll_now),
      .tx_start       (tx_start),
      .tx_cmd         (tx_cmd),
      .tx_done        (tx_done),
      .rx_start       (rx_start),
      .rx_done        (rx_done),
      .jb_cntlr_status(jb_cntlr_status),
      .jb_cntlr_data  (jb_cntlr_data),
      .btn_status     (btn_status),
      .btn_data       (btn_data),
      .upd            (upd),
      .valid          (valid),
      .ctrl_present   (ctrl_present),
      .err_cnt        (err_cnt),
      .state_dbg      (state_dbg)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // transmitter model: tx_done sampled TX_DLY edges after tx_start
   initial begin
      tx_done = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (tx_start && resp_tx) begin
            repeat (TX_DLY - 1) @(posedge clk);
            #1 tx_done = 1'b1;
            @(posedge clk); #1 tx_done = 1'b0;
         end
      end
   end

   // receiver model: rx_done sampled rx_dly edges after rx_start
   initial begin
      rx_done         = 1'b0;
      jb_cntlr_status = 8'hAA;
      jb_cntlr_data   = 16'hDEAD;
      forever begin
         @(posedge clk); #1;
         if (rx_start && resp_rx) begin
            repeat (rx_dly - 1) @(posedge clk);
            #1;
            rx_done         = 1'b1;
            jb_cntlr_status = rsp_status;
            jb_cntlr_data   = rsp_data;
            @(posedge clk); #1;
            rx_done         = 1'b0;
            jb_cntlr_status = 8'hAA;
            jb_cntlr_data   = 16'hDEAD;
         end
      end
   end

   // monitor, sampling on the falling edge
   always @(negedge clk) begin
      if (tx_start) begin
         n_tx++;
         tx_cycs.push_back(cyc);
         last_tx_cyc = cyc;
      end
      if (tx_done) last_txdone_cyc = cyc;
      if (rx_start) begin
         n_rx++;
         last_rxstart_cyc = cyc;
      end
      if (upd) begin
         n_upd++;
         last_upd_cyc = cyc;
      end
      if (err_cnt != prev_err) last_err_cyc = cyc;
      prev_err = err_cnt;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk); #2;
      end
   endtask

   task automatic wait_rx_start(input string tag, input int budget);
      int base;
      int i;
      base = n_rx;
      i = 0;
      while (n_rx == base && i < budget) begin
         tick(1);
         i++;
      end
      check_eq(tag, 32'(n_rx != base), 32'd1);
   endtask

   task automatic wait_upd(input string tag, input int budget);
      int base;
      int i;
      base = n_upd;
      i = 0;
      while (n_upd == base && i < budget) begin
         tick(1);
         i++;
      end
      check_eq(tag, 32'(n_upd != base), 32'd1);
   endtask

   task automatic wait_err(input string tag, input logic [7:0] target, input int budget);
      int i;
      i = 0;
      while (err_cnt < target && i < budget) begin
         tick(1);
         i++;
      end
      check_eq(tag, 32'(err_cnt >= target), 32'd1);
   endtask

   function automatic int count_tx(input int lo, input int hi);
      int n;
      n = 0;
      foreach (tx_cycs[i]) if (tx_cycs[i] >= lo && tx_cycs[i] <= hi) n++;
      return n;
   endfunction

   task automatic check_all_zero(input string pfx);
      check_eq({pfx, "_tx_start"}, 32'(tx_start), 32'd0);
      check_eq({pfx, "_rx_start"}, 32'(rx_start), 32'd0);
      check_eq({pfx, "_upd"}, 32'(upd), 32'd0);
      check_eq({pfx, "_valid"}, 32'(valid), 32'd0);
      check_eq({pfx, "_present"}, 32'(ctrl_present), 32'd0);
      check_eq({pfx, "_btn_status"}, 32'(btn_status), 32'd0);
      check_eq({pfx, "_btn_data"}, 32'(btn_data), 32'd0);
      check_eq({pfx, "_err_cnt"}, 32'(err_cnt), 32'd0);
      check_eq({pfx, "_state"}, 32'(state_dbg), 32'd0);
   endtask

   initial begin
      rst_n      = 1'b0;
      en         = 1'b0;
      poll_now   = 1'b0;
      resp_tx    = 1'b1;
      resp_rx    = 1'b1;
      rx_dly     = 30;
      rsp_status = 8'h05;
      rsp_data   = 16'h3301;

      // reset state
      tick(3);
      check_all_zero("rst");
      check_eq("rst_tx_cmd", 32'(tx_cmd), 32'h01);
      rst_n = 1'b1;
      tick(2);

      // normal poll via poll_now
      c0 = cyc;
      en = 1'b1;
      poll_now = 1'b1;
      tick(1);
      poll_now = 1'b0;
      wait_upd("poll_upd_seen", 100);
      check_eq("poll_start_latency", 32'(last_tx_cyc - c0), 32'd1);
      check_eq("poll_btn_status", 32'(btn_status), 32'h05);
      check_eq("poll_btn_data", 32'(btn_data), 32'h3301);
      check_eq("poll_valid", 32'(valid), 32'd1);
      check_eq("poll_present", 32'(ctrl_present), 32'd1);
      check_eq("poll_tx_to_rx", 32'(last_rxstart_cyc - last_tx_cyc), 32'd20);
      check_eq("poll_rxstart_after_txdone", 32'(last_rxstart_cyc - last_txdone_cyc), 32'd1);
      check_eq("poll_rx_to_upd", 32'(last_upd_cyc - last_rxstart_cyc), 32'd30);
      check_eq("poll_err_cnt", 32'(err_cnt), 32'd0);
      tick(1);
      check_eq("poll_upd_one_cycle", 32'(upd), 32'd0);

      // periodic schedule over 1000 cycles
      t0 = cyc;
      tick(1000);
      win.delete();
      foreach (tx_cycs[i]) if (tx_cycs[i] > t0 && tx_cycs[i] <= t0 + 1000) win.push_back(tx_cycs[i]);
      check_eq("sched_count", 32'(win.size()), 32'd5);
      for (int i = 1; i < win.size(); i++) check_eq("sched_spacing", 32'(win[i] - win[i-1]), 32'd200);
      check_eq("sched_first_phase", 32'((win[0] - (c0 + 1)) % P), 32'd0);

      // no controller: two consecutive misses
      resp_rx = 1'b0;
      wait_err("miss1_seen", 8'd1, 500);
      check_eq("miss1_rx_phase_len", 32'(last_err_cyc - last_rxstart_cyc), 32'd50);
      check_eq("miss1_valid", 32'(valid), 32'd0);
      check_eq("miss1_present", 32'(ctrl_present), 32'd1);
      check_eq("miss1_btn_data", 32'(btn_data), 32'h3301);
      wait_err("miss2_seen", 8'd2, 500);
      check_eq("miss2_rx_phase_len", 32'(last_err_cyc - last_rxstart_cyc), 32'd50);
      check_eq("miss2_present", 32'(ctrl_present), 32'd0);
      check_eq("miss2_err_cnt", 32'(err_cnt), 32'd2);
      check_eq("miss2_btn_data", 32'(btn_data), 32'h3301);
      check_eq("miss2_btn_status", 32'(btn_status), 32'h05);

      // poll_now while busy in RX
      resp_rx = 1'b1;
      rx_dly  = 30;
      wait_rx_start("busy_rx_seen", 400);
      s = last_tx_cyc;
      tick(3);
      poll_now = 1'b1;
      tick(1);
      poll_now = 1'b0;
      tick(5);
      poll_now = 1'b1;
      tick(1);
      poll_now = 1'b0;
      wait_upd("busy_upd_seen", 100);
      u = last_upd_cyc;
      check_eq("busy_present_back", 32'(ctrl_present), 32'd1);
      check_eq("busy_valid", 32'(valid), 32'd1);
      while (cyc < s + 202) tick(1);
      check_eq("busy_extra_count", 32'(count_tx(s + 1, s + 199)), 32'd1);
      check_eq("busy_extra_latency", 32'(count_tx(u + 1, u + 1)), 32'd1);
      check_eq("busy_sched_kept", 32'(count_tx(s + 200, s + 200)), 32'd1);

      // response on the watchdog-expiry edge counts as success
      rx_dly = TO;
      wait_rx_start("edge_rx_seen", 100);
      wait_upd("edge_upd_seen", 100);
      check_eq("edge_rx_to_upd", 32'(last_upd_cyc - last_rxstart_cyc), 32'd50);
      check_eq("edge_err_cnt", 32'(err_cnt), 32'd2);
      check_eq("edge_valid", 32'(valid), 32'd1);

      // one cycle late: miss, then the rx_done lands in IDLE
      rx_dly = TO + 1;
      n0 = n_upd;
      wait_err("late_miss_seen", 8'd3, 400);
      tick(3);
      check_eq("late_spurious_no_upd", 32'(n_upd), 32'(n0));
      check_eq("late_err_cnt", 32'(err_cnt), 32'd3);
      check_eq("late_valid", 32'(valid), 32'd0);
      check_eq("late_present", 32'(ctrl_present), 32'd1);
      check_eq("late_state", 32'(state_dbg), 32'd0);

      // reset mid-RX
      rx_dly = 30;
      wait_rx_start("rst_rx_seen", 400);
      tick(5);
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      en = 1'b0;
      n0 = n_upd;
      tick(40);
      check_eq("midrst_no_upd", 32'(n_upd), 32'(n0));

      // disabled: no polls
      rst_n = 1'b1;
      n0 = n_tx;
      tick(1000);
      check_eq("dis_no_tx", 32'(n_tx), 32'(n0));
      check_eq("dis_state", 32'(state_dbg), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
